wn_phase_comp_scheduler: RTL

WN_PHASE_COMP_SCHEDULER -- requirements
Module: wn_phase_comp_scheduler

---
 rtl/wn_phase_compensation_pkg.sv | 33 +++
 rtl/wn_rr_arbiter2.sv | 31 +++
 rtl/wn_phase_comp_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wn_phase_compensation_pkg.sv
// Shared types for the phase-compensation symbol scheduler.
// Config word layout, FSM states, request layout, slot limit.
package wn_phase_compensation_pkg;

  typedef struct packed {
    logic        enable_phase_compensation;
    logic [2:0]  numerology;
    logic [31:0] cf;
    logic [1:0]  phase_compensation_mode;
  } config_phaseCompensation;

  typedef enum logic [1:0] {
    CFG_WAIT,
    IDLE,
    ISSUE,
    WAIT_DONE
  } sched_state_e;

  typedef struct packed {
    logic [2:0] pad;
    logic       chan;
    logic [3:0] sym;
    logic [7:0] slot;
  } phase_req_t;

  // Slots per frame is 10 << numerology; numerology saturates at 4.
  function automatic logic [8:0] slot_limit(input logic [2:0] numerology);
    logic [2:0] n;
    n = (numerology > 3'd4) ? 3'd4 : numerology;
    return 9'd10 << n;
  endfunction

endpackage

// File: rtl/wn_rr_arbiter2.sv
// Two-way round-robin arbiter for the antenna channels.
// The pointer picks the winner on a tie and flips on update.
module wn_rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       ptr_update,
  output logic [1:0] grant
);

  logic ptr;

  // Flip preference once the served channel has finished its slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (ptr_update) begin
      ptr <= ~ptr;
    end
  end

  // A lone request always wins; the pointer breaks ties.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = req;
    endcase
  end

endmodule

// File: rtl/wn_phase_comp_scheduler.sv
// Serialises per-channel slot requests into symbol requests
// for the shared phase-parameter generator, one at a time.
module wn_phase_comp_scheduler
  import wn_phase_compensation_pkg::*;
#(
  parameter int NUM_SYM = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  config_phaseCompensation config_in_tdata,
  input  logic                    config_in_tvalid,
  output logic                    config_in_tready,
  input  logic [7:0]              slot_num_in_0_tdata,
  input  logic                    slot_num_in_0_tvalid,
  output logic                    slot_num_in_0_tready,
  input  logic [7:0]              slot_num_in_1_tdata,
  input  logic                    slot_num_in_1_tvalid,
  output logic                    slot_num_in_1_tready,
  output logic [15:0]             phase_req_tdata,
  output logic                    phase_req_tvalid,
  input  logic                    phase_req_tready,
  output logic                    phase_req_tlast,
  input  logic                    sym_done,
  output logic                    bypass,
  output logic                    err_slot,
  output logic                    active_chan
);

  localparam logic [3:0] LAST_SYM = 4'(NUM_SYM - 1);

  sched_state_e            state;
  config_phaseCompensation cfg_q;
  logic                    live_q;
  logic                    bypass_q;
  logic                    err_q;
  logic [1:0]              ready_q;
  logic [7:0]              slot_q;
  logic [3:0]              sym_q;
  logic                    chan_q;

  logic [1:0] slot_valid;
  logic [1:0] grant;
  logic       sel_valid;
  logic [7:0] sel_slot;
  logic       slot_bad;
  logic       cfg_hs;
  logic       last_done;
  logic       unused_cfg;
  phase_req_t req;

  assign slot_valid = {slot_num_in_1_tvalid, slot_num_in_0_tvalid};
  assign sel_valid  = ready_q[0] ? slot_num_in_0_tvalid
                                 : slot_num_in_1_tvalid;
  assign sel_slot   = ready_q[0] ? slot_num_in_0_tdata
                                 : slot_num_in_1_tdata;
  assign slot_bad   = {1'b0, sel_slot} >= slot_limit(cfg_q.numerology);
  assign cfg_hs     = config_in_tvalid & config_in_tready;
  assign last_done  = (state == WAIT_DONE) & sym_done
                    & (sym_q == LAST_SYM);
  assign unused_cfg = ^{cfg_q.cf, cfg_q.phase_compensation_mode};

  wn_rr_arbiter2 u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (slot_valid),
    .ptr_update (last_done),
    .grant      (grant)
  );

  // Marks the first cycle after reset so ready rises only then.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Main scheduler: config latch, grant, issue, completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CFG_WAIT;
      cfg_q    <= '0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 2'b00;
      slot_q   <= 8'd0;
      sym_q    <= 4'd0;
      chan_q   <= 1'b0;
    end else begin
      unique case (state)
        CFG_WAIT: begin
          if (cfg_hs) begin
            cfg_q    <= config_in_tdata;
            bypass_q <= ~config_in_tdata.enable_phase_compensation;
            err_q    <= 1'b0;
            state    <= IDLE;
          end
        end
        IDLE: begin
          if (cfg_hs) begin
            cfg_q    <= config_in_tdata;
            bypass_q <= ~config_in_tdata.enable_phase_compensation;
            err_q    <= 1'b0;
          end else if (!bypass_q) begin
            if (ready_q != 2'b00) begin
              ready_q <= 2'b00;
              if (sel_valid) begin
                if (slot_bad) begin
                  err_q <= 1'b1;
                end else begin
                  slot_q <= sel_slot;
                  chan_q <= ready_q[1];
                  sym_q  <= 4'd0;
                  state  <= ISSUE;
                end
              end
            end else if (|slot_valid && !config_in_tvalid) begin
              ready_q <= grant;
            end
          end
        end
        ISSUE: begin
          if (phase_req_tready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (sym_done) begin
            if (sym_q == LAST_SYM) begin
              state <= IDLE;
            end else begin
              sym_q <= sym_q + 4'd1;
              state <= ISSUE;
            end
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    req      = '0;
    req.chan = chan_q;
    req.sym  = sym_q;
    req.slot = slot_q;
  end

  assign config_in_tready = live_q
                          & ((state == CFG_WAIT)
                          | ((state == IDLE) & (ready_q == 2'b00)));
  assign slot_num_in_0_tready = (state == IDLE)
                              & (bypass_q | ready_q[0]);
  assign slot_num_in_1_tready = (state == IDLE)
                              & (bypass_q | ready_q[1]);
  assign phase_req_tdata  = req;
  assign phase_req_tvalid = (state == ISSUE);
  assign phase_req_tlast  = (state == ISSUE) & (sym_q == LAST_SYM);
  assign bypass           = bypass_q;
  assign err_slot         = err_q;
  assign active_chan      = chan_q;

endmodule
